wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Program sequencer for the washer datapath; sits between the synchronized button/tick sources and the view logic.
- Latches the selected program (wash/rinse/dry) and step durations at start, then walks the fill, wash, drain, spin and rinse steps one second at a time.
- Handles pause/resume and door-open interlock, and reports the current step (one-hot LEDs), remaining times and finish/beep.

Parameters:
- BEEP_SECS, 3: number of ticks `beep` stays high after completion (1..15).
- TW, 6: width of per-step duration inputs and `stepLeft`.

Ports:
- clk  in  1  system clock
- resetBtn  in  1  synchronous, active-high reset
- tick  in  1  one-clk pulse per second
- runBtn  in  1  one-clk pulse: start / pause / resume
- openBtn  in  1  level, 1 = door open
- mode  in  3  program select: bit2 wash, bit1 rinse, bit0 dry
- waterTime  in  3  fill/drain seconds; 0 treated as 1
- washTime  in  TW  wash seconds; 0 treated as 1
- rinseTime  in  TW  rinse seconds; 0 treated as 1
- spinTime  in  TW  spin seconds; 0 treated as 1
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
- stepLED  out  8  one-hot current step; bit order [7:0] = wIn, wWash, rOut, rSpin, rIn, rRinse, dOut, dSpin
- stepLeft  out  TW  seconds left in current step
- remain  out  9  total seconds left in program
- finish  out  1  one-clk pulse on entering DONE
- beep  out  1  high during DONE

Behaviour:
- Reset (sync, any state, mid-run included):
  - state=IDLE; stepLED, stepLeft, remain, finish and beep all 0.
  - Latched configuration cleared.
- Step list, filtered by the latched mode, in this order:
  - wash: wIn(water), wWash(wash)
  - rinse: rOut(water), rSpin(spin), rIn(water), rRinse(rinse)
  - dry: dOut(water), dSpin(spin)
- IDLE:
  - runBtn with mode≠0 and openBtn=0 → RUN on the next edge.
  - On that edge: latch mode and all times (zero→1 substitution applied), load the first enabled step into stepLED/stepLeft, and load remain = sum of all enabled step durations (max 280, fits 9 bits).
  - runBtn with mode=0 or door open is ignored.
  - A tick in the same cycle as the start is not counted.
- RUN, per tick with no pause event in that cycle:
  - stepLeft and remain each decrement by 1.
  - If stepLeft was 1: advance to the next enabled step, loading its duration; if none remains → DONE.
  - Input changes mid-run have no effect.
- RUN → PAUSE when runBtn=1 or openBtn=1. Pause wins over a same-cycle tick; that tick is dropped.
- PAUSE:
  - Counters frozen; stepLED held.
  - runBtn with openBtn=0 → RUN. Closing the door alone never resumes.
  - runBtn while the door is open is ignored.
- DONE:
  - Entry edge: finish=1 for exactly one clk; stepLED=0, stepLeft=0, remain=0; beep=1.
  - Beep counter loads BEEP_SECS and decrements per tick; when it reaches 0, beep=0 and state→IDLE.
  - runBtn in DONE is ignored.
  - openBtn has no effect in DONE or IDLE (other than blocking start).
- Invariants:
  - stepLED is exactly one-hot in RUN/PAUSE and 0 in IDLE/DONE.
  - remain always equals the sum of stepLeft and the durations of all later enabled steps.
  - No counter wraps below 0.
- Latency: all outputs registered; a response is visible the edge after the causing input.

Test Plan:
- Reset, mode=3'b100, water=2, wash=3, runBtn → stepLED=8'h80, stepLeft=2, remain=5. After 2 ticks: 8'h40, stepLeft=3, remain=3. After 3 more ticks: finish pulse, state=DONE, beep=1. After 3 ticks: state=IDLE, beep=0.
- mode=3'b011, water=1, spin=2, rinse=2 → steps rOut,rSpin,rIn,rRinse,dOut,dSpin with remain=9; stepLED sequence 20,10,08,04,02,01 hex, each held for its duration.
- Mid-wash, openBtn=1 → PAUSE, counters frozen over 5 ticks. openBtn=0 alone stays in PAUSE. runBtn → RUN, counting resumes from the same values.
- runBtn and tick in the same RUN cycle → PAUSE, stepLeft unchanged. runBtn in IDLE with mode=0 or door open → stays IDLE.
- washTime=0 → wWash lasts 1 tick. Input changes to mode/times during RUN leave remain/sequence unchanged.
- resetBtn asserted in RUN with stepLeft=5 → next edge state=IDLE, all outputs 0. A fresh runBtn restarts from the first step.

Source files
------------

// File: rtl/wash_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wash_sequencer
//  Purpose  : Washer program sequencer. Latches the selected program and the
//             step durations at start, then walks fill/wash/drain/spin/rinse
//             steps one tick (second) at a time, with pause/resume, a door
//             interlock, remaining-time reporting and a completion beep.
//  Revision : 1.0  initial release
// ============================================================================
module wash_sequencer #(
   parameter int BEEP_SECS = 3,   // ticks beep stays high after completion (1..15)
   parameter int TW        = 6    // width of per-step durations and stepLeft
) (
   input  logic          clk,
   input  logic          resetBtn,
   input  logic          tick,
   input  logic          runBtn,
   input  logic          openBtn,
   input  logic [2:0]    mode,
   input  logic [2:0]    waterTime,
   input  logic [TW-1:0] washTime,
   input  logic [TW-1:0] rinseTime,
   input  logic [TW-1:0] spinTime,
   output logic [1:0]    state,
   output logic [7:0]    stepLED,
   output logic [TW-1:0] stepLeft,
   output logic [8:0]    remain,
   output logic          finish,
   output logic          beep
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Step index 0..7 maps to stepLED bit 7..0:
   //   0 wIn, 1 wWash, 2 rOut, 3 rSpin, 4 rIn, 5 rRinse, 6 dOut, 7 dSpin

   // Which steps belong to the programs selected by a mode word.
   function automatic logic [7:0] step_enables(input logic [2:0] m);
      return {m[0], m[0], m[1], m[1], m[1], m[1], m[2], m[2]};
   endfunction

   // Duration of a step given the (already zero-substituted) times.
   function automatic logic [TW-1:0] step_dur(input logic [2:0]    idx,
                                             input logic [2:0]    w,
                                             input logic [TW-1:0] wa,
                                             input logic [TW-1:0] ri,
                                             input logic [TW-1:0] sp);
      logic [TW-1:0] d;
      case (idx)
         3'd1:       d = wa;
         3'd3, 3'd7: d = sp;
         3'd5:       d = ri;
         default:    d = TW'(w);
      endcase
      return d;
   endfunction

   // One-hot LED pattern for a step index.
   function automatic logic [7:0] step_led(input logic [2:0] idx);
      return 8'h80 >> idx;
   endfunction

   // ------------------------------------------------------------------------
   // State and latched configuration
   // ------------------------------------------------------------------------
   state_t        state_q,  state_d;
   logic [2:0]    mode_q,   mode_d;
   logic [2:0]    water_q,  water_d;
   logic [TW-1:0] wash_q,   wash_d;
   logic [TW-1:0] rinse_q,  rinse_d;
   logic [TW-1:0] spin_q,   spin_d;
   logic [2:0]    step_q,   step_d;
   logic [7:0]    led_q,    led_d;
   logic [TW-1:0] left_q,   left_d;
   logic [8:0]    remain_q, remain_d;
   logic          finish_q, finish_d;
   logic          beep_q,   beep_d;
   logic [3:0]    bcnt_q,   bcnt_d;

   // ------------------------------------------------------------------------
   // Start-time view of the inputs (zero durations count as one second)
   // ------------------------------------------------------------------------
   logic [2:0]    w_water_nz;
   logic [TW-1:0] w_wash_nz;
   logic [TW-1:0] w_rinse_nz;
   logic [TW-1:0] w_spin_nz;
   logic [7:0]    w_en_in;
   logic [7:0]    w_en_q;
   logic [8:0]    w_start_total;

   assign w_water_nz = (waterTime == 3'd0) ? 3'd1 : waterTime;
   assign w_wash_nz  = (washTime  == '0)   ? TW'(1) : washTime;
   assign w_rinse_nz = (rinseTime == '0)   ? TW'(1) : rinseTime;
   assign w_spin_nz  = (spinTime  == '0)   ? TW'(1) : spinTime;
   assign w_en_in    = step_enables(mode);
   assign w_en_q     = step_enables(mode_q);

   // Whole-program length: water steps appear once in wash, twice in rinse
   // and once in dry; the total fits 9 bits for the default widths.
   assign w_start_total =
        (mode[2] ? (9'(w_water_nz) + 9'(w_wash_nz)) : 9'd0)
      + (mode[1] ? (9'(w_water_nz) + 9'(w_water_nz) + 9'(w_spin_nz) + 9'(w_rinse_nz)) : 9'd0)
      + (mode[0] ? (9'(w_water_nz) + 9'(w_spin_nz)) : 9'd0);

   // First enabled step of the requested program.
   logic [2:0] w_first_idx;
   always_comb begin
      w_first_idx = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         if (w_en_in[j]) w_first_idx = 3'(j);
      end
   end

   // Next enabled step after the current one in the latched program.
   logic [2:0] w_next_idx;
   logic       w_has_next;
   always_comb begin
      w_next_idx = 3'd0;
      w_has_next = 1'b0;
      for (int j = 7; j >= 0; j--) begin
         if (w_en_q[j] && (3'(j) > step_q)) begin
            w_next_idx = 3'(j);
            w_has_next = 1'b1;
         end
      end
   end

   // Next-state and output computation for the sequencer FSM.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      water_d  = water_q;
      wash_d   = wash_q;
      rinse_d  = rinse_q;
      spin_d   = spin_q;
      step_d   = step_q;
      led_d    = led_q;
      left_d   = left_q;
      remain_d = remain_q;
      finish_d = 1'b0;
      beep_d   = beep_q;
      bcnt_d   = bcnt_q;

      unique case (state_q)
         S_IDLE: begin
            // Start needs a program and a closed door; any tick this cycle
            // is not counted against the first step.
            if (runBtn && (mode != 3'd0) && !openBtn) begin
               state_d  = S_RUN;
               mode_d   = mode;
               water_d  = w_water_nz;
               wash_d   = w_wash_nz;
               rinse_d  = w_rinse_nz;
               spin_d   = w_spin_nz;
               step_d   = w_first_idx;
               led_d    = step_led(w_first_idx);
               left_d   = step_dur(w_first_idx, w_water_nz, w_wash_nz,
                                   w_rinse_nz, w_spin_nz);
               remain_d = w_start_total;
            end
         end

         S_RUN: begin
            // Pause request beats a coincident tick, which is dropped.
            if (runBtn || openBtn) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               if (left_q <= TW'(1)) begin
                  if (w_has_next) begin
                     step_d   = w_next_idx;
                     led_d    = step_led(w_next_idx);
                     left_d   = step_dur(w_next_idx, water_q, wash_q,
                                         rinse_q, spin_q);
                     remain_d = (remain_q != 9'd0) ? remain_q - 9'd1 : 9'd0;
                  end else begin
                     state_d  = S_DONE;
                     led_d    = 8'h00;
                     left_d   = '0;
                     remain_d = 9'd0;
                     finish_d = 1'b1;
                     beep_d   = 1'b1;
                     bcnt_d   = 4'(BEEP_SECS);
                  end
               end else begin
                  left_d   = left_q - TW'(1);
                  remain_d = (remain_q != 9'd0) ? remain_q - 9'd1 : 9'd0;
               end
            end
         end

         S_PAUSE: begin
            // Only an explicit run press with the door shut resumes.
            if (runBtn && !openBtn) state_d = S_RUN;
         end

         S_DONE: begin
            if (tick) begin
               if (bcnt_q <= 4'd1) begin
                  bcnt_d  = 4'd0;
                  beep_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  bcnt_d = bcnt_q - 4'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset clearing all state and config.
   always_ff @(posedge clk) begin
      if (resetBtn) begin
         state_q  <= S_IDLE;
         mode_q   <= 3'd0;
         water_q  <= 3'd0;
         wash_q   <= '0;
         rinse_q  <= '0;
         spin_q   <= '0;
         step_q   <= 3'd0;
         led_q    <= 8'h00;
         left_q   <= '0;
         remain_q <= 9'd0;
         finish_q <= 1'b0;
         beep_q   <= 1'b0;
         bcnt_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         water_q  <= water_d;
         wash_q   <= wash_d;
         rinse_q  <= rinse_d;
         spin_q   <= spin_d;
         step_q   <= step_d;
         led_q    <= led_d;
         left_q   <= left_d;
         remain_q <= remain_d;
         finish_q <= finish_d;
         beep_q   <= beep_d;
         bcnt_q   <= bcnt_d;
      end
   end

   assign state    = state_q;
   assign stepLED  = led_q;
   assign stepLeft = left_q;
   assign remain   = remain_q;
   assign finish   = finish_q;
   assign beep     = beep_q;

endmodule
`default_nettype wire

// File: tb/tb_wash_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wash_sequencer
//  Purpose  : Directed scoreboard bench for wash_sequencer. The driver pushes
//             the hand-computed expectation for each checked edge into a
//             queue; a negedge monitor pops and compares against the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wash_sequencer;

   logic       clk = 1'b0;
   logic       resetBtn = 1'b0;
   logic       tick = 1'b0;
   logic       runBtn = 1'b0;
   logic       openBtn = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [2:0] waterTime = 3'd0;
   logic [5:0] washTime = 6'd0;
   logic [5:0] rinseTime = 6'd0;
   logic [5:0] spinTime = 6'd0;
   logic [1:0] state;
   logic [7:0] stepLED;
   logic [5:0] stepLeft;
   logic [8:0] remain;
   logic       finish;
   logic       beep;

   wash_sequencer #(.BEEP_SECS(3), .TW(6)) dut (
      .clk(clk), .resetBtn(resetBtn), .tick(tick), .runBtn(runBtn),
      .openBtn(openBtn), .mode(mode), .waterTime(waterTime),
      .washTime(washTime), .rinseTime(rinseTime), .spinTime(spinTime),
      .state(state), .stepLED(stepLED), .stepLeft(stepLeft),
      .remain(remain), .finish(finish), .beep(beep)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  st;
      logic [7:0]  led;
      logic [5:0]  left;
      logic [8:0]  rem;
      logic        fin;
      logic        bp;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          nvec = 0;
   int          nmis = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation tagged for the edge just passed.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         nvec++;
         if (e.cyc != cyc ||
             {state, stepLED, stepLeft, remain, finish, beep} !==
             {e.st, e.led, e.left, e.rem, e.fin, e.bp}) begin
            nmis++;
            $display("FAIL vec%0d cyc%0d: got st=%0d led=%h left=%0d rem=%0d fin=%b beep=%b; want st=%0d led=%h left=%0d rem=%0d fin=%b beep=%b",
                     nvec, e.cyc, state, stepLED, stepLeft, remain, finish, beep,
                     e.st, e.led, e.left, e.rem, e.fin, e.bp);
         end
      end
   end

   // One clock with the given pulse/level inputs, no check.
   task automatic cy(input logic t, input logic r, input logic o);
      tick = t; runBtn = r; openBtn = o;
      @(posedge clk); #1;
      tick = 1'b0; runBtn = 1'b0;
   endtask

   // One clock, expecting the given outputs right after the edge.
   task automatic ck(input logic t, input logic r, input logic o,
                     input logic [1:0] st, input logic [7:0] led,
                     input logic [5:0] left, input logic [8:0] rem,
                     input logic fin, input logic bp);
      exp_t e;
      e.cyc = cyc + 1; e.st = st; e.led = led; e.left = left;
      e.rem = rem; e.fin = fin; e.bp = bp;
      sb.push_back(e);
      cy(t, r, o);
   endtask

   task automatic do_reset();
      resetBtn = 1'b1;
      ck(0, 0, 0, 2'd0, 8'h00, 6'd0, 9'd0, 0, 0);
      resetBtn = 1'b0;
   endtask

   // Three ticks of beep, the last returning to IDLE.
   task automatic beep_out();
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 0, 1);
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 0, 1);
      ck(1, 0, 0, 2'd0, 8'h00, 6'd0, 9'd0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- Reset and wash-only program ----
      do_reset();
      mode = 3'b100; waterTime = 3'd2; washTime = 6'd3;
      rinseTime = 6'd7; spinTime = 6'd7;
      ck(0, 1, 0, 2'd1, 8'h80, 6'd2, 9'd5, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h80, 6'd1, 9'd4, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd3, 9'd3, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd2, 9'd2, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd1, 9'd1, 0, 0);
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 1, 1);
      ck(0, 1, 0, 2'd3, 8'h00, 6'd0, 9'd0, 0, 1);   // run ignored in DONE
      beep_out();

      // ---- Rinse + dry program ----
      mode = 3'b011; waterTime = 3'd1; spinTime = 6'd2;
      rinseTime = 6'd2; washTime = 6'd5;
      ck(0, 1, 0, 2'd1, 8'h20, 6'd1, 9'd9, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h10, 6'd2, 9'd8, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h10, 6'd1, 9'd7, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h08, 6'd1, 9'd6, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h04, 6'd2, 9'd5, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h04, 6'd1, 9'd4, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h02, 6'd1, 9'd3, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h01, 6'd2, 9'd2, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h01, 6'd1, 9'd1, 0, 0);
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 1, 1);
      beep_out();

      // ---- Pause / resume and door interlock ----
      mode = 3'b100; waterTime = 3'd1; washTime = 6'd4;
      ck(0, 1, 0, 2'd1, 8'h80, 6'd1, 9'd5, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd4, 9'd4, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd3, 9'd3, 0, 0);
      ck(0, 0, 1, 2'd2, 8'h40, 6'd3, 9'd3, 0, 0);   // door opens
      for (int i = 0; i < 5; i++)
         ck(1, 0, 1, 2'd2, 8'h40, 6'd3, 9'd3, 0, 0); // frozen
      ck(0, 1, 1, 2'd2, 8'h40, 6'd3, 9'd3, 0, 0);   // run with door open
      ck(1, 0, 0, 2'd2, 8'h40, 6'd3, 9'd3, 0, 0);   // door closed alone
      ck(0, 1, 0, 2'd1, 8'h40, 6'd3, 9'd3, 0, 0);   // resume
      ck(1, 0, 0, 2'd1, 8'h40, 6'd2, 9'd2, 0, 0);
      ck(1, 1, 0, 2'd2, 8'h40, 6'd2, 9'd2, 0, 0);   // pause beats tick
      ck(0, 1, 0, 2'd1, 8'h40, 6'd2, 9'd2, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h40, 6'd1, 9'd1, 0, 0);
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 1, 1);
      beep_out();

      // ---- Start ignored with mode 0 or door open ----
      mode = 3'b000;
      ck(0, 1, 0, 2'd0, 8'h00, 6'd0, 9'd0, 0, 0);
      mode = 3'b100;
      ck(1, 1, 1, 2'd0, 8'h00, 6'd0, 9'd0, 0, 0);

      // ---- washTime 0 counts as 1, mid-run input changes ignored ----
      waterTime = 3'd1; washTime = 6'd0;
      ck(1, 1, 0, 2'd1, 8'h80, 6'd1, 9'd2, 0, 0);   // start tick not counted
      mode = 3'b011; waterTime = 3'd7; washTime = 6'd9; spinTime = 6'd20;
      ck(1, 0, 0, 2'd1, 8'h40, 6'd1, 9'd1, 0, 0);
      ck(1, 0, 0, 2'd3, 8'h00, 6'd0, 9'd0, 1, 1);
      beep_out();

      // ---- Reset mid-run, then fresh start (water 0 counts as 1) ----
      mode = 3'b001; waterTime = 3'd0; spinTime = 6'd5;
      ck(0, 1, 0, 2'd1, 8'h02, 6'd1, 9'd6, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h01, 6'd5, 9'd5, 0, 0);
      resetBtn = 1'b1;
      ck(1, 0, 0, 2'd0, 8'h00, 6'd0, 9'd0, 0, 0);
      resetBtn = 1'b0;
      ck(0, 1, 0, 2'd1, 8'h02, 6'd1, 9'd6, 0, 0);
      ck(1, 0, 0, 2'd1, 8'h01, 6'd5, 9'd5, 0, 0);

      // Drain the scoreboard.
      cy(0, 0, 0);
      cy(0, 0, 0);
      if (sb.size() != 0) begin
         nvec++;
         nmis++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
`default_nettype wire
